// File: rtl/alu16_seq_ctrl.sv
// Cycle-by-cycle control sequencer for the 16-bit A/M/Q ALU datapath:
// single-cycle ADD/SUB, radix-2 Booth signed multiply, non-restoring unsigned divide.
module alu16_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             q0,
    input  logic             qm1,
    input  logic             a_msb,
    output logic             ld_m,
    output logic             ld_a_bus,
    output logic             ld_q,
    output logic             clr_a,
    output logic             ld_a,
    output logic             alu_sub,
    output logic             asr,
    output logic             shl,
    output logic             q_set,
    output logic             qbit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_M, S_LOAD_X, S_EXEC, S_MUL_CHK, S_MUL_SHIFT,
        S_DIV_SHIFT, S_DIV_OP, S_DIV_Q, S_DIV_FIX, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sgn_q, sgn_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
        end
    end

    // Handshake: start is a one-cycle request taken only in IDLE (no ready, no queue);
    // the caller watches busy and waits for the one-cycle done pulse.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        ld_m     = 1'b0;
        ld_a_bus = 1'b0;
        ld_q     = 1'b0;
        clr_a    = 1'b0;
        ld_a     = 1'b0;
        alu_sub  = 1'b0;
        asr      = 1'b0;
        shl      = 1'b0;
        q_set    = 1'b0;
        qbit     = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    state_d = S_LOAD_M;
                end
            end
            S_LOAD_M: begin
                ld_m    = 1'b1;
                state_d = S_LOAD_X;
            end
            S_LOAD_X: begin
                if (!op_q[1]) begin
                    ld_a_bus = 1'b1;
                    state_d  = S_EXEC;
                end else begin
                    ld_q    = 1'b1;
                    clr_a   = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = op_q[0] ? S_DIV_SHIFT : S_MUL_CHK;
                end
            end
            S_EXEC: begin
                ld_a    = 1'b1;
                alu_sub = op_q[0];
                state_d = S_DONE;
            end
            S_MUL_CHK: begin
                // Booth pair 10 subtracts M, 01 adds M, 00/11 just shift
                if (q0 != qm1) begin
                    ld_a    = 1'b1;
                    alu_sub = q0;
                end
                state_d = S_MUL_SHIFT;
            end
            S_MUL_SHIFT: begin
                asr = 1'b1;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                state_d = (cnt_q <= CNT_W'(1)) ? S_DONE : S_MUL_CHK;
            end
            S_DIV_SHIFT: begin
                sgn_d   = a_msb;
                shl     = 1'b1;
                state_d = S_DIV_OP;
            end
            S_DIV_OP: begin
                ld_a    = 1'b1;
                alu_sub = ~sgn_q;
                state_d = S_DIV_Q;
            end
            S_DIV_Q: begin
                q_set = 1'b1;
                qbit  = ~a_msb;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                state_d = (cnt_q <= CNT_W'(1)) ? S_DIV_FIX : S_DIV_SHIFT;
            end
            S_DIV_FIX: begin
                // Negative remainder after the last step gets M added back
                if (a_msb) ld_a = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt       = cnt_q;
    assign dbg_state = state_q;

endmodule
